// File: rtl/lifo_stack.sv
// lifo_stack: hardware LIFO with a registered top-of-stack output.
// The stack body sits in one synchronous-read RAM. The top entry is also
// kept in the data_o register, so a pop reads the entry below the top
// (address count-2) straight into data_o with no extra latency.
// Push on full and pop on empty change nothing except a sticky error flag.
module lifo_stack #(
  parameter int XLEN        = 32,
  parameter int SIZE        = 7,
  parameter int AFULL_LEVEL = 2**SIZE - 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  output logic [SIZE:0]   count_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            almost_full_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam int DEPTH = 2**SIZE;
  localparam logic [SIZE:0] DEPTH_C = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0] AFULL_C = (SIZE+1)'(AFULL_LEVEL);
  localparam logic [SIZE:0] ONE_C   = (SIZE+1)'(1);
  localparam logic [SIZE:0] TWO_C   = (SIZE+1)'(2);

  logic [XLEN-1:0] mem [DEPTH];

  logic [SIZE:0]   count_q;
  logic [SIZE:0]   count_d;
  logic [SIZE:0]   cnt_m1;
  logic [SIZE:0]   cnt_m2;
  logic            is_empty;
  logic            is_full;
  logic            wr_en;
  logic [SIZE-1:0] wr_addr;
  logic [SIZE-1:0] rd_addr;
  logic            data_load_in;
  logic            data_load_ram;
  logic            data_zero;
  logic            set_ovf;
  logic            set_unf;

  assign cnt_m1   = count_q - ONE_C;
  assign cnt_m2   = count_q - TWO_C;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign rd_addr  = cnt_m2[SIZE-1:0];

  // Flags are pure functions of the occupancy count.
  assign count_o       = count_q;
  assign empty_o       = is_empty;
  assign full_o        = is_full;
  assign almost_full_o = (count_q >= AFULL_C);

  // Decode {pop, push} into next count, RAM write, data_o source and error sets.
  always_comb begin
    count_d       = count_q;
    wr_en         = 1'b0;
    wr_addr       = count_q[SIZE-1:0];
    data_load_in  = 1'b0;
    data_load_ram = 1'b0;
    data_zero     = 1'b0;
    set_ovf       = 1'b0;
    set_unf       = 1'b0;
    unique case ({pop_i, push_i})
      2'b01: begin
        if (is_full) begin
          set_ovf = 1'b1;
        end else begin
          wr_en        = 1'b1;
          data_load_in = 1'b1;
          count_d      = count_q + ONE_C;
        end
      end
      2'b10: begin
        if (is_empty) begin
          set_unf = 1'b1;
        end else if (count_q == ONE_C) begin
          data_zero = 1'b1;
          count_d   = '0;
        end else begin
          data_load_ram = 1'b1;
          count_d       = cnt_m1;
        end
      end
      2'b11: begin
        // Replace the top in place; on an empty stack this is a plain push.
        wr_en        = 1'b1;
        data_load_in = 1'b1;
        if (is_empty) begin
          count_d = ONE_C;
        end else begin
          wr_addr = cnt_m1[SIZE-1:0];
        end
      end
      default: ;
    endcase
    if (clear_i) begin
      wr_en = 1'b0;
    end
  end

  // Stack storage: single write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= data_i;
    end
  end

  // Occupancy, top-of-stack register and sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= '0;
      data_o      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clear_i) begin
      count_q     <= '0;
      data_o      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      count_q <= count_d;
      if (data_load_in) begin
        data_o <= data_i;
      end else if (data_load_ram) begin
        data_o <= mem[rd_addr];
      end else if (data_zero) begin
        data_o <= '0;
      end
      if (set_ovf) overflow_o  <= 1'b1;
      if (set_unf) underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Testbench for lifo_stack (SIZE=3, 8 entries) against a queue-based model.
module tb_lifo_stack;

  localparam int XLEN  = 32;
  localparam int SIZE  = 3;
  localparam int DEPTH = 8;
  localparam int AFULL = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            clear_i;
  logic            push_i;
  logic            pop_i;
  logic [XLEN-1:0] data_i;
  logic [XLEN-1:0] data_o;
  logic [SIZE:0]   count_o;
  logic            empty_o;
  logic            full_o;
  logic            almost_full_o;
  logic            overflow_o;
  logic            underflow_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [XLEN-1:0] model_q [$];
  logic            model_ovf;
  logic            model_unf;

  lifo_stack #(.XLEN(XLEN), .SIZE(SIZE)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
  endtask

  task automatic model_apply(input logic c, input logic ps, input logic pp, input logic [XLEN-1:0] d);
    if (c) begin
      model_reset();
    end else if (ps && pp) begin
      if (model_q.size() == 0) model_q.push_back(d);
      else model_q[model_q.size()-1] = d;
    end else if (ps) begin
      if (model_q.size() == DEPTH) model_ovf = 1'b1;
      else model_q.push_back(d);
    end else if (pp) begin
      if (model_q.size() == 0) model_unf = 1'b1;
      else void'(model_q.pop_back());
    end
  endtask

  task automatic check_all();
    int n;
    logic [XLEN-1:0] top;
    n   = model_q.size();
    top = (n == 0) ? '0 : model_q[n-1];
    chk("data",  64'(data_o), 64'(top));
    chk("count", 64'(count_o), 64'(n));
    chk("empty", 64'(empty_o), 64'(n == 0));
    chk("full",  64'(full_o), 64'(n == DEPTH));
    chk("afull", 64'(almost_full_o), 64'(n >= AFULL));
    chk("ovf",   64'(overflow_o), 64'(model_ovf));
    chk("unf",   64'(underflow_o), 64'(model_unf));
  endtask

  // Called #1 after a rising edge: drive, take one edge, update model, check.
  task automatic step(input logic c, input logic ps, input logic pp, input logic [XLEN-1:0] d);
    clear_i = c;
    push_i  = ps;
    pop_i   = pp;
    data_i  = d;
    @(posedge clk_i);
    model_apply(c, ps, pp, d);
    #1;
    check_all();
  endtask

  initial begin
    rst_i   = 1'b1;
    clear_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    data_i  = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst_i = 1'b0;

    // Push three, pop four (last one underflows).
    step(0, 1, 0, 32'h11);
    step(0, 1, 0, 32'h22);
    step(0, 1, 0, 32'h33);
    repeat (4) step(0, 0, 1, 32'h0);
    chk("unf_dir", 64'(underflow_o), 64'd1);

    step(1, 0, 0, 32'h0);

    // Fill to full, overflow once, drain, then one extra pop.
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 32'(i));
    chk("full_dir", 64'(full_o), 64'd1);
    step(0, 1, 0, 32'h99);
    chk("ovf_top", 64'(data_o), 64'd8);
    repeat (8) step(0, 0, 1, 32'h0);
    step(0, 0, 1, 32'h0);

    // Clear together with a push: flags drop, push ignored.
    step(1, 1, 0, 32'hDEAD);
    chk("clr_cnt", 64'(count_o), 64'd0);

    // Replace semantics.
    step(0, 1, 0, 32'h11);
    step(0, 1, 0, 32'h22);
    step(0, 1, 1, 32'hAA);
    chk("repl_top", 64'(data_o), 64'hAA);
    step(0, 0, 1, 32'h0);
    chk("repl_pop", 64'(data_o), 64'h11);
    step(0, 0, 1, 32'h0);
    step(0, 1, 1, 32'h55);
    chk("repl_empty", 64'(data_o), 64'h55);
    // Replace when full: no overflow.
    for (int i = 0; i < 7; i++) step(0, 1, 0, 32'(i + 100));
    step(0, 1, 1, 32'hBEEF);

    // Asynchronous reset mid-cycle with count = 5.
    step(1, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'(i + 200));
    clear_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(0, 1, 0, 32'h7);

    // Randomised traffic with a drifting push/pop bias to visit full and empty.
    for (int i = 0; i < 3000; i++) begin
      int r;
      int bias;
      logic c, ps, pp;
      bias = ((i / 200) % 2 == 0) ? 70 : 30;
      r  = $urandom_range(0, 99);
      c  = ($urandom_range(0, 63) == 0);
      ps = ($urandom_range(0, 99) < bias);
      pp = ($urandom_range(0, 99) < (100 - bias));
      if (r < 5) begin
        ps = 1'b1;
        pp = 1'b1;
      end
      step(c, ps, pp, $urandom);
    end

    clear_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised hardware LIFO (call/return or expression stack) with registered top-of-stack output, level reporting, full/empty flags and sticky overflow/underflow error flags.
- Successor to the original BRAM stack: adds asynchronous reset, synchronous flush, simultaneous push+pop "replace top" semantics, and correct full/empty guarding; push on full or pop on empty is never destructive.
- Storage maps onto one inferred synchronous-read block RAM. Sits beside the CPU core (return-address stack) or any datapath needing a hardware stack.

Parameters:
- XLEN, 32, entry width in bits.
- SIZE, 7, log2 of depth; DEPTH = 2**SIZE entries (minimum SIZE = 1).
- AFULL_LEVEL, 2**SIZE-4, count at or above which almost_full_o asserts (range 1..DEPTH).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous flush: empties stack and clears error flags.
- push_i  input  1  push data_i this cycle.
- pop_i  input  1  pop top entry this cycle.
- data_i  input  XLEN  push data.
- data_o  output  XLEN  current top-of-stack (registered); 0 when empty.
- count_o  output  SIZE+1  number of valid entries, 0..DEPTH.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == DEPTH.
- almost_full_o  output  1  count_o >= AFULL_LEVEL.
- overflow_o  output  1  sticky: a push was attempted while full.
- underflow_o  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst_i high, asynchronous): count = 0, data_o = 0, overflow_o = underflow_o = 0. RAM contents not reset. Outputs hold reset values while rst_i is high; normal operation begins on the first rising edge after deassertion.
- Storage: entry k (0 = bottom) lives at RAM address k. Top entry is address count-1 and is mirrored in the data_o register. All flags are combinational from count.
- Latency: data_o and count_o reflect an operation on the clock edge that performs it, i.e. visible in the cycle after push_i/pop_i is sampled. No stalls; the block accepts one operation per cycle.
- Priority per edge: clear_i > operation decode. When clear_i is high: count <= 0, data_o <= 0, both error flags <= 0, and push/pop are ignored.
- Decode of {pop_i, push_i}:
  - 00: hold.
  - 01 push, not full: RAM[count] <= data_i; data_o <= data_i; count++.
  - 01 push, full: no state change except overflow_o <= 1.
  - 10 pop, count >= 2: RAM read address count-2; data_o <= RAM[count-2]; count--.
  - 10 pop, count == 1: data_o <= 0; count <= 0.
  - 10 pop, empty: no state change except underflow_o <= 1.
  - 11 replace, count >= 1: RAM[count-1] <= data_i; data_o <= data_i; count unchanged. Legal when full; no overflow.
  - 11 replace, empty: behaves as a plain push (count <= 1, data_o <= data_i); no underflow.
- RAM: single write port, single synchronous read port. Read and write addresses are never equal in the same cycle, so no read-during-write bypass is required.
- Width rules: count is SIZE+1 bits so DEPTH is representable. RAM address is count[SIZE-1:0] arithmetic and never wraps because the full/empty guards prevent it.
- Error flags clear only on rst_i or clear_i.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> data_o 0x11, 0x22, 0x33 on following cycles; count_o = 3; empty_o = 0.
- From that state, pop three times -> data_o 0x22, 0x11, then 0; count_o 2, 1, 0; empty_o = 1. A fourth pop -> underflow_o = 1, count_o stays 0.
- SIZE=3: push 8 values 1..8 -> full_o = 1, almost_full_o asserted at count 4. A ninth push of 0x99 -> overflow_o = 1, data_o stays 8. Then pop 8 times -> data_o 7..1, then 0.
- Count = 2 (top 0x22): push+pop with 0xAA -> data_o = 0xAA, count_o = 2. Pop -> data_o = 0x11. On empty, push+pop with 0x55 -> count_o = 1, data_o = 0x55, no error flags.
- Set both error flags, then clear_i asserted together with push_i -> count_o = 0, data_o = 0, flags 0, push ignored.
- Assert rst_i asynchronously mid-cycle with count = 5 -> all outputs return to reset values before the next edge. After release, push 0x7 -> data_o = 7, count_o = 1.
